// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port, 1-cycle-latency BRAM between instruction fetch (IF) and load/store (LS).
// Optional starvation guard for IF is enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [31:0]           if_rdata,
    input  logic                  ls_req,
    input  logic [3:0]            ls_wstrb,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [31:0]           ls_wdata,
    output logic                  ls_gnt,
    output logic                  ls_rvalid,
    output logic [31:0]           ls_rdata,
    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    output logic [1:0]            dbg_resp_owner,
    output logic [3:0]            dbg_starve_cnt
);

    // Handshake: a request is accepted in the cycle where req && gnt; the requester
    // holds req, address and data stable until then. rvalid follows exactly one cycle later.

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_IF    = 2'd1,
        OWN_LS_RD = 2'd2
    } owner_t;

    owner_t owner_q, owner_d;
    logic   force_if;
    logic   unused_addr_bits;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [3:0] starve_q;

    // Counts consecutive contended LS wins; saturates rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= 4'd0;
        end else if (!if_req || if_gnt) begin
            starve_q <= 4'd0;
        end else if (ls_gnt && starve_q != 4'hF) begin
            starve_q <= starve_q + 4'd1;
        end
    end

    assign force_if       = (starve_q == 4'(STARVE_LIMIT));
    assign dbg_starve_cnt = starve_q;
`else
    assign force_if       = 1'b0;
    assign dbg_starve_cnt = 4'd0;
`endif

    // LS holds the older instruction, so it wins contention unless IF is forced.
    assign if_gnt = !rst && if_req && (!ls_req || force_if);
    assign ls_gnt = !rst && ls_req && !(if_req && force_if);

    assign mem_en    = if_gnt | ls_gnt;
    assign mem_we    = ls_gnt ? ls_wstrb : 4'd0;
    assign mem_addr  = ls_gnt ? ls_addr[ADDR_WIDTH-1:2] : if_addr[ADDR_WIDTH-1:2];
    assign mem_wdata = ls_wdata;

    assign unused_addr_bits = ^{if_addr[1:0], ls_addr[1:0]};

    always_comb begin
        owner_d = OWN_NONE;
        if (if_gnt) begin
            owner_d = OWN_IF;
        end else if (ls_gnt && ls_wstrb == 4'd0) begin
            owner_d = OWN_LS_RD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Gating with rst discards a response that was pending when reset arrived.
    assign if_rvalid      = !rst && (owner_q == OWN_IF);
    assign ls_rvalid      = !rst && (owner_q == OWN_LS_RD);
    assign if_rdata       = if_rvalid ? mem_rdata : 32'd0;
    assign ls_rdata       = ls_rvalid ? mem_rdata : 32'd0;
    assign dbg_resp_owner = owner_q;

endmodule
